midi_tx_queue: RTL

- Buffered MIDI transmit stage. Sits directly downstream of the controller's message-select logic and drives the MIDI OUT pin.
- Accepts whole MIDI messages (status plus 0–2 data bytes) through a valid/ready port and queues up to DEPTH of them.
- Serialises each queued message as 31250-baud UART frames (1 start, 8 data LSB-first, 1 stop).
- Back-to-back button presses are therefore never lost while a previous message is still on the wire.

---
 rtl/midi_tx_queue_pkg.sv | 41 ++++
 rtl/midi_tx_queue_if.sv | 27 ++
 rtl/midi_tx_queue_fifo.sv | 66 ++++++
 rtl/midi_tx_queue.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/midi_tx_queue_pkg.sv
// ============================================================================
// Module      : midi_pkg
// Description : Shared message type, FSM encoding and constants for the
//               buffered MIDI transmit stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package midi_pkg;

  localparam int          MIDI_BAUD_CNT_100MHZ = 3200;
  localparam logic [7:0]  STATUS_SYS_MIN       = 8'hF0;
  localparam logic [7:0]  STATUS_CH_MIN        = 8'h80;

  typedef struct packed {
    logic [7:0] status;
    logic [7:0] data1;
    logic [7:0] data2;
    logic [1:0] len;
  } midi_msg_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_STOP  = 3'd4
  } tx_state_e;

  // Wire order of a message: status, data1, data2.
  function automatic logic [7:0] msg_byte(input midi_msg_t msg, input logic [1:0] idx);
    case (idx)
      2'd0:    return msg.status;
      2'd1:    return msg.data1;
      default: return msg.data2;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/midi_tx_queue_if.sv
// ============================================================================
// Module      : midi_tx_queue_if
// Description : Valid/ready message port into the MIDI transmit queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface midi_tx_queue_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_status;
  logic [7:0] wr_data1;
  logic [7:0] wr_data2;
  logic [1:0] wr_len;

  modport master (
    output wr_valid, wr_status, wr_data1, wr_data2, wr_len,
    input  wr_ready
  );

  modport slave (
    input  wr_valid, wr_status, wr_data1, wr_data2, wr_len,
    output wr_ready
  );
endinterface

`default_nettype wire

// File: rtl/midi_tx_queue_fifo.sv
// ============================================================================
// Module      : midi_msg_fifo
// Description : Synchronous DEPTH-entry FIFO of whole MIDI messages.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module midi_msg_fifo
  import midi_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  input  wire logic                     push,
  input  wire midi_msg_t                din,
  input  wire logic                     pop,
  output midi_msg_t                     dout,
  output logic [$clog2(DEPTH):0]        level,
  output logic                          full,
  output logic                          empty
);

  localparam int                AW           = $clog2(DEPTH);
  localparam logic [AW:0]       c_FULL_LEVEL = (AW+1)'(DEPTH);

  midi_msg_t       r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_level;
  logic            w_push;
  logic            w_pop;

  assign full   = (r_level == c_FULL_LEVEL);
  assign empty  = (r_level == '0);
  assign level  = r_level;
  assign dout   = r_mem[r_rd_ptr];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/midi_tx_queue.sv
// ============================================================================
// Module      : midi_tx_queue
// Description : Message queue plus 31250-baud UART serialiser for MIDI OUT.
//               Optional running-status suppression: MIDI_RUNNING_STATUS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module midi_tx_queue
  import midi_pkg::*;
#(
  parameter int BAUD_CNT = MIDI_BAUD_CNT_100MHZ,
  parameter int DEPTH    = 4
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  midi_tx_queue_if.slave            wr,
  output logic                      midi_tx,
  output logic                      busy,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      overflow
);

  localparam int              CW          = $clog2(BAUD_CNT);
  localparam logic [CW-1:0]   c_BAUD_LAST = CW'(BAUD_CNT - 1);

  tx_state_e   r_state;
  midi_msg_t   r_msg;
  logic [1:0]  r_byte_idx;
  logic [2:0]  r_bit_idx;
  logic [CW-1:0] r_baud;
  logic [7:0]  r_shift;
  logic        r_tx;
  logic        r_overflow;

  midi_msg_t   w_head;
  midi_msg_t   w_msg_in;
  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;
  logic        w_baud_end;
  logic        w_skip;
  logic [1:0]  w_first_idx;

  assign wr.wr_ready = !rst && !w_full;
  // A zero-length message is acknowledged but never stored.
  assign w_push      = wr.wr_valid && wr.wr_ready && (wr.wr_len != 2'd0);
  assign w_pop       = (r_state == ST_LOAD);
  assign w_msg_in    = '{status: wr.wr_status, data1: wr.wr_data1,
                         data2: wr.wr_data2, len: wr.wr_len};

  midi_msg_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .din   (w_msg_in),
    .pop   (w_pop),
    .dout  (w_head),
    .level (level),
    .full  (w_full),
    .empty (w_empty)
  );

`ifdef MIDI_RUNNING_STATUS_EN
  logic [7:0] r_last_status;
  logic       w_is_chan;

  assign w_is_chan = (w_head.status >= STATUS_CH_MIN) && (w_head.status < STATUS_SYS_MIN);
  assign w_skip    = w_is_chan && (w_head.status == r_last_status);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_status <= '0;
    end else if (r_state == ST_LOAD) begin
      if (w_head.status >= STATUS_SYS_MIN) r_last_status <= '0;
      else if (w_is_chan)                  r_last_status <= w_head.status;
    end
  end
`else
  assign w_skip = 1'b0;
`endif

  assign w_first_idx = w_skip ? 2'd1 : 2'd0;
  assign w_baud_end  = (r_baud == c_BAUD_LAST);
  assign midi_tx     = r_tx;
  assign overflow    = r_overflow;
  assign busy        = (r_state != ST_IDLE) || !w_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_msg      <= '0;
      r_byte_idx <= '0;
      r_bit_idx  <= '0;
      r_baud     <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (wr.wr_valid && !wr.wr_ready) r_overflow <= 1'b1;

      if ((r_state == ST_START || r_state == ST_DATA || r_state == ST_STOP) && !w_baud_end)
        r_baud <= r_baud + 1'b1;
      else
        r_baud <= '0;

      case (r_state)
        ST_IDLE: begin
          if (!w_empty) r_state <= ST_LOAD;
        end
        ST_LOAD: begin
          r_msg <= w_head;
          // A lone status byte that running status suppresses has nothing left to send.
          if (w_skip && w_head.len == 2'd1) begin
            r_state <= ST_IDLE;
          end else begin
            r_byte_idx <= w_first_idx;
            r_shift    <= msg_byte(w_head, w_first_idx);
            r_tx       <= 1'b0;
            r_state    <= ST_START;
          end
        end
        ST_START: begin
          if (w_baud_end) begin
            r_bit_idx <= '0;
            r_tx      <= r_shift[0];
            r_state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_baud_end) begin
            if (r_bit_idx == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= ST_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
              r_shift   <= {1'b0, r_shift[7:1]};
              r_tx      <= r_shift[1];
            end
          end
        end
        ST_STOP: begin
          if (w_baud_end) begin
            if (r_byte_idx != r_msg.len - 2'd1) begin
              r_byte_idx <= r_byte_idx + 2'd1;
              r_shift    <= msg_byte(r_msg, r_byte_idx + 2'd1);
              r_tx       <= 1'b0;
              r_state    <= ST_START;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
